// File: rtl/dst_pkg.sv
// dst_pkg: shared bank state type, default geometry and sizing helpers
// for the dst_dbuf ping-pong result buffer.
package dst_pkg;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_e;

    localparam int DEF_RES_W = 32;
    localparam int DEF_LANES = 2;
    localparam int DEF_DEPTH = 64;

    function automatic int calc_words(input int depth, input int lanes);
        return depth / lanes;
    endfunction

    function automatic int calc_aw(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dst_bank.sv
// dst_bank: one buffer bank; LANES result-wide memories written one slot at a
// time and read one full row per cycle through a registered read port.
module dst_bank import dst_pkg::*; #(
    parameter int RES_W = DEF_RES_W,
    parameter int LANES = DEF_LANES,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = calc_aw(DEPTH),
    localparam int RW = calc_aw(calc_words(DEPTH, LANES))
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [RES_W-1:0]       wdata,
    input  logic                   re,
    input  logic [RW-1:0]          raddr,
    output logic [RES_W*LANES-1:0] rdata
);
    localparam int WORDS = calc_words(DEPTH, LANES);

    logic [31:0]   slot;
    logic [RW-1:0] wrow;

    assign slot = 32'(waddr);
    assign wrow = RW'(slot / LANES);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [RES_W-1:0] mem [WORDS];
        logic [RES_W-1:0] q;
        always_ff @(posedge clk) begin
            if (we && slot % LANES == 32'(l)) mem[wrow] <= wdata;
            if (re) q <= mem[raddr];
        end
        assign rdata[l*RES_W +: RES_W] = q;
    end

endmodule

// File: rtl/dst_dbuf.sv
// dst_dbuf: ping-pong result buffer; results are collected into one bank while
// the other drains as LANES-wide stream words under valid/ready.
module dst_dbuf import dst_pkg::*; #(
    parameter int RES_W = DEF_RES_W,
    parameter int LANES = DEF_LANES,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = calc_aw(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   out_period,
    input  logic [AW-1:0]          out_addr,
    input  logic [RES_W-1:0]       result,
    input  logic                   wr_done,
    output logic                   wr_ready,
    output logic                   stream_valid,
    input  logic                   stream_ready,
    output logic [RES_W*LANES-1:0] stream_d,
    output logic                   stream_last,
    output logic                   ovf
);
    localparam int WORDS = calc_words(DEPTH, LANES);
    localparam int RW    = calc_aw(WORDS);
    localparam int DW    = RES_W * LANES;

    bank_state_e   bst [2];
    logic          wsel, rsel, isel;
    logic [1:0]    iss_done;
    logic [RW-1:0] rcnt;
    logic          inf, inf_bank, inf_last;
    logic [DW-1:0] rdata [2];
    logic [DW-1:0] sd [2];
    logic [1:0]    sl, cnt, nxt;
    logic [DW-1:0] rd;
    logic          we, issue, rlast, pop, shift, push;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dst_bank #(.RES_W(RES_W), .LANES(LANES), .DEPTH(DEPTH)) u_bank (
            .clk  (clk),
            .we   (we && wsel == 1'(b)),
            .waddr(out_addr),
            .wdata(result),
            .re   (issue && isel == 1'(b)),
            .raddr(rcnt),
            .rdata(rdata[b])
        );
    end

    assign wr_ready = bst[wsel] == EMPTY;
    assign we       = out_period & wr_ready;
    assign rlast    = rcnt == RW'(WORDS - 1);
    // The issue pointer runs ahead of rsel so the next FULL bank is prefetched
    // while the current one finishes draining; the in-flight read counts as a slot.
    assign issue    = bst[isel] == FULL && !iss_done[isel] && (cnt + {1'b0, inf}) < 2'd2;

    assign rd           = rdata[inf_bank];
    assign stream_valid = cnt != 2'd0 || inf;
    assign stream_d     = cnt != 2'd0 ? sd[0] : inf ? rd : '0;
    assign stream_last  = cnt != 2'd0 ? sl[0] : inf & inf_last;
    assign pop          = stream_valid & stream_ready;
    assign shift        = pop & (cnt != 2'd0);
    assign push         = inf & ~(pop & (cnt == 2'd0));
    assign nxt          = cnt - {1'b0, shift};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bst      <= '{EMPTY, EMPTY};
            wsel     <= 1'b0;
            rsel     <= 1'b0;
            isel     <= 1'b0;
            iss_done <= '0;
            rcnt     <= '0;
            inf      <= 1'b0;
            inf_bank <= 1'b0;
            inf_last <= 1'b0;
            sd       <= '{default: '0};
            sl       <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
        end else begin
            if (wr_done && wr_ready) begin
                bst[wsel] <= FULL;
                wsel      <= ~wsel;
            end
            if (pop && stream_last) begin
                bst[rsel]      <= EMPTY;
                iss_done[rsel] <= 1'b0;
                rsel           <= ~rsel;
            end
            ovf <= ovf | (~wr_ready & (out_period | wr_done));
            inf <= issue;
            if (issue) begin
                inf_bank <= isel;
                inf_last <= rlast;
                rcnt     <= rlast ? '0 : rcnt + RW'(1);
                if (rlast) begin
                    iss_done[isel] <= 1'b1;
                    isel           <= ~isel;
                end
            end
            if (shift) begin
                sd[0] <= sd[1];
                sl[0] <= sl[1];
            end
            if (push) begin
                sd[nxt[0]] <= rd;
                sl[nxt[0]] <= inf_last;
            end
            cnt <= nxt + {1'b0, push};
        end
    end

endmodule

// File: tb/tb_dst_dbuf.sv
// tb_dst_dbuf: directed and random checks of dst_dbuf against a bank-queue
// reference model; a second 4-lane instance checks lane packing.
module tb_dst_dbuf;

    localparam int WD = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        out_period = 1'b0, wr_done = 1'b0, stream_ready = 1'b0;
    logic [5:0]  out_addr = '0;
    logic [31:0] result = '0;
    logic        wr_ready, stream_valid, stream_last, ovf;
    logic [63:0] stream_d;

    dst_dbuf #(.RES_W(32), .LANES(2), .DEPTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .out_period(out_period), .out_addr(out_addr),
        .result(result), .wr_done(wr_done), .wr_ready(wr_ready),
        .stream_valid(stream_valid), .stream_ready(stream_ready),
        .stream_d(stream_d), .stream_last(stream_last), .ovf(ovf));

    logic         b_period = 1'b0, b_done = 1'b0, b_ready = 1'b0;
    logic [3:0]   b_addr = '0;
    logic [31:0]  b_result = '0;
    logic         b_wr_ready, b_valid, b_last, b_ovf;
    logic [127:0] b_d;

    dst_dbuf #(.RES_W(32), .LANES(4), .DEPTH(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .out_period(b_period), .out_addr(b_addr),
        .result(b_result), .wr_done(b_done), .wr_ready(b_wr_ready),
        .stream_valid(b_valid), .stream_ready(b_ready),
        .stream_d(b_d), .stream_last(b_last), .ovf(b_ovf));

    int n_assert = 0, n_fail = 0;

    // Reference model: slot contents per bank, queue of words owed to the
    // stream, and the number of banks handed off but not yet drained.
    logic [31:0] mem [2][64];
    logic [63:0] expq [$];
    int          full_banks = 0, mwsel = 0, pos = 0, n_acc = 0;
    logic        exp_ovf = 1'b0;
    logic        prev_stall = 1'b0, prev_last = 1'b0;
    logic [63:0] prev_d = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        expq.delete();
        full_banks = 0;
        mwsel      = 0;
        pos        = 0;
        exp_ovf    = 1'b0;
        prev_stall = 1'b0;
    endtask

    // Called at a falling edge with inputs settled: check, update model, advance a cycle.
    task automatic tick();
        logic ok, acc, was_last;
        chk("wr_ready", wr_ready, full_banks < 2);
        chk("ovf", ovf, exp_ovf);
        if (prev_stall) begin
            chk("hold_valid", stream_valid, 1'b1);
            chk("hold_data", stream_d, prev_d);
            chk("hold_last", stream_last, prev_last);
        end
        acc      = stream_valid && stream_ready;
        was_last = pos == WD - 1;
        if (acc) begin
            chk("q_nonempty", expq.size() != 0, 1'b1);
            if (expq.size() != 0) chk("word", stream_d, expq.pop_front());
            chk("last", stream_last, was_last);
            pos = (pos + 1) % WD;
            n_acc++;
        end
        ok = full_banks < 2;
        if (acc && was_last) full_banks--;
        if (out_period) begin
            if (ok) mem[mwsel][out_addr] = result;
            else exp_ovf = 1'b1;
        end
        if (wr_done) begin
            if (ok) begin
                for (int k = 0; k < WD; k++) expq.push_back({mem[mwsel][2*k+1], mem[mwsel][2*k]});
                full_banks++;
                mwsel ^= 1;
            end else exp_ovf = 1'b1;
        end
        prev_stall = stream_valid && !stream_ready;
        prev_d     = stream_d;
        prev_last  = stream_last;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill(input bit rnd, input logic [31:0] base);
        for (int a = 0; a < 64; a++) begin
            out_period = 1'b1;
            out_addr   = 6'(a);
            result     = rnd ? $urandom : base + 32'(a);
            tick();
        end
        out_period = 1'b0;
    endtask

    task automatic handoff();
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
    endtask

    task automatic drain(input int words, input bit rnd);
        int tgt;
        tgt = n_acc + words;
        for (int i = 0; i < 5000 && n_acc < tgt; i++) begin
            stream_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
        end
        chk("drain_count", n_acc, tgt);
    endtask

    initial begin
        int tgt, bk;
        repeat (2) @(negedge clk);
        chk("rst_valid", stream_valid, 1'b0);
        chk("rst_d", stream_d, 64'h0);
        chk("rst_last", stream_last, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single bank at full rate
        fill(1'b0, 32'h100);
        handoff();
        chk("lat_gap", stream_valid, 1'b0);
        stream_ready = 1'b1;
        tick();
        chk("w0", stream_d, 64'h00000101_00000100);
        for (int i = 0; i < WD; i++) begin
            chk("run_valid", stream_valid, 1'b1);
            tick();
        end
        chk("run_end", stream_valid, 1'b0);
        chk("q_empty1", expq.size(), 0);

        // Both banks full, then overflow attempts, then random-ready drain
        stream_ready = 1'b0;
        fill(1'b1, 0);
        handoff();
        fill(1'b1, 0);
        handoff();
        chk("both_full", wr_ready, 1'b0);
        out_period = 1'b1;
        out_addr   = 6'd5;
        result     = $urandom;
        tick();
        out_period = 1'b0;
        chk("ovf_set", ovf, 1'b1);
        handoff();
        drain(2 * WD, 1'b1);
        chk("q_empty2", expq.size(), 0);

        // Two prefetched banks stream back to back without a bubble
        stream_ready = 1'b0;
        fill(1'b1, 0);
        handoff();
        fill(1'b1, 0);
        handoff();
        stream_ready = 1'b1;
        for (int i = 0; i < 2 * WD; i++) begin
            chk("b2b_valid", stream_valid, 1'b1);
            tick();
        end
        chk("b2b_end", stream_valid, 1'b0);

        // Last-word acceptance coinciding with wr_done on the other bank
        stream_ready = 1'b0;
        fill(1'b1, 0);
        handoff();
        fill(1'b1, 0);
        stream_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (stream_valid && stream_last) break;
            tick();
        end
        chk("sim_reach", stream_valid && stream_last, 1'b1);
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        chk("sim_wr_ready", wr_ready, 1'b1);
        chk("sim_gap", stream_valid, 1'b0);
        tick();
        chk("sim_next", stream_valid, 1'b1);
        drain(WD, 1'b0);
        chk("q_empty3", expq.size(), 0);

        // Reset in the middle of a drain
        stream_ready = 1'b0;
        fill(1'b1, 0);
        handoff();
        stream_ready = 1'b1;
        tgt = n_acc + 10;
        for (int i = 0; i < 200 && n_acc < tgt; i++) tick();
        chk("rst_reach", n_acc, tgt);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", stream_valid, 1'b0);
        chk("mid_rst_wr_ready", wr_ready, 1'b1);
        chk("mid_rst_d", stream_d, 64'h0);
        chk("mid_rst_ovf", ovf, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        stream_ready = 1'b0;
        fill(1'b0, 32'h200);
        handoff();
        stream_ready = 1'b1;
        tick();
        chk("post_rst_w0", stream_d, 64'h00000201_00000200);
        drain(WD, 1'b0);
        chk("q_empty4", expq.size(), 0);

        // Four-lane packing
        for (int a = 0; a < 16; a++) begin
            b_period = 1'b1;
            b_addr   = 4'(a);
            b_result = 32'(a);
            @(posedge clk);
            @(negedge clk);
        end
        b_period = 1'b0;
        b_done   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_done  = 1'b0;
        b_ready = 1'b1;
        bk = 0;
        for (int i = 0; i < 20 && bk < 4; i++) begin
            if (b_valid) begin
                chk("l4_word", b_d, {32'(4*bk+3), 32'(4*bk+2), 32'(4*bk+1), 32'(4*bk)});
                chk("l4_last", b_last, bk == 3);
                bk++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("l4_count", bk, 4);
        chk("l4_wr_ready", b_wr_ready, 1'b1);
        chk("l4_ovf", b_ovf, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
